// File: rtl/charging_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : charging_pkg
//  Purpose  : Counter-record layout, policy codes and record pack/unpack
//             helpers shared by the charging pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package charging_pkg;

    localparam int REC_W = 512;
    localparam int RPT_W = 22;
    localparam int FLD_W = 48;

    // Bit offsets inside the 512-bit counter record
    localparam int QUO_EN_LSB   = 0;
    localparam int QUO_HOST_BIT = 3;
    localparam int QUO_TOT_LSB  = 8;
    localparam int QUO_UL_LSB   = 56;
    localparam int QUO_DL_LSB   = 104;
    localparam int THR_EN_LSB   = 152;
    localparam int THR_HOST_BIT = 155;
    localparam int THR_TOT_LSB  = 160;
    localparam int THR_UL_LSB   = 208;
    localparam int THR_DL_LSB   = 256;
    localparam int CNT_UL_LSB   = 304;
    localparam int CNT_DL_LSB   = 352;
    localparam int LAST_TS_LSB  = 464;

    localparam int POLICY_W = 3;
    localparam logic [POLICY_W-1:0] POLICY_DROP = 3'd1;
    localparam logic [POLICY_W-1:0] POLICY_HOST = 3'd2;
    localparam logic [POLICY_W-1:0] POLICY_PASS = 3'd4;

    typedef struct packed {
        logic [2:0]       quo_en;
        logic             quo_host;
        logic [FLD_W-1:0] quo_tot;
        logic [FLD_W-1:0] quo_ul;
        logic [FLD_W-1:0] quo_dl;
        logic [2:0]       thr_en;
        logic             thr_host;
        logic [FLD_W-1:0] thr_tot;
        logic [FLD_W-1:0] thr_ul;
        logic [FLD_W-1:0] thr_dl;
        logic [FLD_W-1:0] cnt_ul;
        logic [FLD_W-1:0] cnt_dl;
        logic [FLD_W-1:0] last_ts;
    } rec_t;

    function automatic rec_t unpack_record(input logic [REC_W-1:0] raw);
        rec_t r;
        r.quo_en   = raw[QUO_EN_LSB +: 3];
        r.quo_host = raw[QUO_HOST_BIT];
        r.quo_tot  = raw[QUO_TOT_LSB +: FLD_W];
        r.quo_ul   = raw[QUO_UL_LSB +: FLD_W];
        r.quo_dl   = raw[QUO_DL_LSB +: FLD_W];
        r.thr_en   = raw[THR_EN_LSB +: 3];
        r.thr_host = raw[THR_HOST_BIT];
        r.thr_tot  = raw[THR_TOT_LSB +: FLD_W];
        r.thr_ul   = raw[THR_UL_LSB +: FLD_W];
        r.thr_dl   = raw[THR_DL_LSB +: FLD_W];
        r.cnt_ul   = raw[CNT_UL_LSB +: FLD_W];
        r.cnt_dl   = raw[CNT_DL_LSB +: FLD_W];
        r.last_ts  = raw[LAST_TS_LSB +: FLD_W];
        return r;
    endfunction

    // Overlays the struct fields onto base so that unlisted bits survive.
    function automatic logic [REC_W-1:0] pack_record(input logic [REC_W-1:0] base,
                                                     input rec_t r);
        logic [REC_W-1:0] raw;
        raw = base;
        raw[QUO_EN_LSB +: 3]      = r.quo_en;
        raw[QUO_HOST_BIT]         = r.quo_host;
        raw[QUO_TOT_LSB +: FLD_W] = r.quo_tot;
        raw[QUO_UL_LSB +: FLD_W]  = r.quo_ul;
        raw[QUO_DL_LSB +: FLD_W]  = r.quo_dl;
        raw[THR_EN_LSB +: 3]      = r.thr_en;
        raw[THR_HOST_BIT]         = r.thr_host;
        raw[THR_TOT_LSB +: FLD_W] = r.thr_tot;
        raw[THR_UL_LSB +: FLD_W]  = r.thr_ul;
        raw[THR_DL_LSB +: FLD_W]  = r.thr_dl;
        raw[CNT_UL_LSB +: FLD_W]  = r.cnt_ul;
        raw[CNT_DL_LSB +: FLD_W]  = r.cnt_dl;
        raw[LAST_TS_LSB +: FLD_W] = r.last_ts;
        return raw;
    endfunction

    function automatic logic [POLICY_W-1:0] policy_of(input logic exceed, input logic host);
        if (!exceed)   return POLICY_PASS;
        else if (host) return POLICY_HOST;
        else           return POLICY_DROP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/charging_fwd_hist.sv
`default_nettype none
// ============================================================================
//  Module   : charging_fwd_hist
//  Purpose  : Write-back history for read-after-write forwarding. Holds the
//             live stage-C write plus the DEPTH previous cycles of writes and
//             returns the youngest record matching the lookup id.
//  Revision : 1.0 - initial release
// ============================================================================
module charging_fwd_hist
    import charging_pkg::*;
#(
    parameter int ID_W  = 14,
    parameter int DEPTH = 2
) (
    input  logic             asclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_id,
    input  logic [REC_W-1:0] wr_rec,
    input  logic [ID_W-1:0]  lk_id,
    output logic             hit,
    output logic [REC_W-1:0] hit_rec
);

    logic [DEPTH-1:0] r_vld;
    logic [ID_W-1:0]  r_id  [0:DEPTH-1];
    logic [REC_W-1:0] r_rec [0:DEPTH-1];

    // Valid bits shift once per cycle (window is in cycles, not writes); cleared on reset
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[DEPTH-2 >= 0 ? DEPTH-2 : 0:0], wr_en} & {DEPTH{1'b1}};
        end
    end

    // Id/record payload shifts alongside the valid bits
    always_ff @(posedge asclk) begin
        r_id[0]  <= wr_id;
        r_rec[0] <= wr_rec;
        for (int k = 1; k < DEPTH; k++) begin
            r_id[k]  <= r_id[k-1];
            r_rec[k] <= r_rec[k-1];
        end
    end

    // Oldest-to-youngest scan so the youngest match wins; live write is youngest
    always_comb begin
        hit     = 1'b0;
        hit_rec = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (r_vld[k] && (r_id[k] == lk_id)) begin
                hit     = 1'b1;
                hit_rec = r_rec[k];
            end
        end
        if (wr_en && (wr_id == lk_id)) begin
            hit     = 1'b1;
            hit_rec = wr_rec;
        end
    end

endmodule
`default_nettype wire

// File: rtl/charging_counter_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : charging_counter_pipe
//  Purpose  : Fully pipelined per-flow volume charging engine. One descriptor
//             per cycle; same-id hazards resolved by forwarding, no stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module charging_counter_pipe
    import charging_pkg::*;
#(
    parameter int ID_W   = 14,
    parameter int LEN_W  = 16,
    parameter int PID_W  = 96,
    parameter int VOL_W  = 48,
    parameter int TS_W   = 24,
    parameter int RD_LAT = 2
) (
    input  logic                                   asclk,
    input  logic                                   aresetn,
    input  logic [TS_W-1:0]                        timer,
    input  logic [2+ID_W+PID_W+LEN_W-1:0]          in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic                                   mem_rd_en,
    output logic [ID_W-1:0]                        mem_rd_addr,
    input  logic [REC_W-1:0]                       mem_rd_data,
    output logic                                   mem_wr_en,
    output logic [ID_W-1:0]                        mem_wr_addr,
    output logic [REC_W-1:0]                       mem_wr_data,
    input  logic                                   out_afull,
    output logic                                   out_valid,
    output logic [1+RPT_W+1+3+PID_W+LEN_W-1:0]     out_data
);

    localparam int OUT_W = 1 + RPT_W + 1 + POLICY_W + PID_W + LEN_W;

    typedef struct packed {
        logic             ul;
        logic             cnt_en;
        logic [ID_W-1:0]  id;
        logic [PID_W-1:0] pid;
        logic [LEN_W-1:0] len;
    } desc_t;

    // Saturating decrement: returns {exceed, new volume}
    function automatic logic [VOL_W:0] charge(input logic [VOL_W-1:0] vol,
                                              input logic [LEN_W-1:0] len,
                                              input logic             apply);
        logic [VOL_W-1:0] len_x;
        len_x = VOL_W'(len);
        if (!apply)          return {1'b0, vol};
        else if (vol < len_x) return {1'b1, {VOL_W{1'b0}}};
        else                 return {1'b0, vol - len_x};
    endfunction

    desc_t            w_in;
    logic             w_pop;
    desc_t            r_desc [0:RD_LAT];
    logic [RD_LAT:0]  r_vld;
    desc_t            w_m;
    logic             w_m_vld;
    logic             w_hit;
    logic [REC_W-1:0] w_hit_rec;
    logic [REC_W-1:0] w_src;
    rec_t             w_cur;
    rec_t             w_nxt;
    logic [2:0]       w_qx;
    logic [2:0]       w_tx;
    logic [2:0]       w_qpol;
    logic [2:0]       w_tpol;
    logic [2:0]       w_pol;
    logic [RPT_W-1:0] w_rpt;
    logic [OUT_W-1:0] w_out;
    logic [REC_W-1:0] w_wr_rec;

    logic             r_c_valid;
    logic             r_c_wr;
    logic [ID_W-1:0]  r_c_id;
    logic [REC_W-1:0] r_c_rec;
    logic [OUT_W-1:0] r_c_out;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;

    assign w_in     = in_data;
    assign w_pop    = in_valid & ~out_afull;
    assign in_ready = w_pop;

    // Stage A capture plus RD_LAT-deep descriptor delay to meet returning RAM data
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            r_vld     <= '0;
            r_desc[0] <= '0;
        end else begin
            r_vld <= {r_vld[RD_LAT-1:0], w_pop};
            if (w_pop) begin
                r_desc[0] <= w_in;
            end
            for (int k = 1; k <= RD_LAT; k++) begin
                r_desc[k] <= r_desc[k-1];
            end
        end
    end

    assign mem_rd_en   = r_vld[0] & r_desc[0].cnt_en;
    assign mem_rd_addr = r_desc[0].id;

    assign w_m     = r_desc[RD_LAT];
    assign w_m_vld = r_vld[RD_LAT];

    charging_fwd_hist #(
        .ID_W  (ID_W),
        .DEPTH (RD_LAT)
    ) u_hist (
        .asclk   (asclk),
        .aresetn (aresetn),
        .wr_en   (r_c_wr),
        .wr_id   (r_c_id),
        .wr_rec  (r_c_rec),
        .lk_id   (w_m.id),
        .hit     (w_hit),
        .hit_rec (w_hit_rec)
    );

    assign w_src = w_hit ? w_hit_rec : mem_rd_data;

    // Merge-cycle compute: decrement volumes, bump direction count, derive policy and report
    always_comb begin
        w_cur = unpack_record(w_src);
        w_nxt = w_cur;
        {w_qx[0], w_nxt.quo_tot} = charge(w_cur.quo_tot, w_m.len, w_cur.quo_en[0]);
        {w_qx[1], w_nxt.quo_ul}  = charge(w_cur.quo_ul,  w_m.len, w_cur.quo_en[1] &  w_m.ul);
        {w_qx[2], w_nxt.quo_dl}  = charge(w_cur.quo_dl,  w_m.len, w_cur.quo_en[2] & ~w_m.ul);
        {w_tx[0], w_nxt.thr_tot} = charge(w_cur.thr_tot, w_m.len, w_cur.thr_en[0]);
        {w_tx[1], w_nxt.thr_ul}  = charge(w_cur.thr_ul,  w_m.len, w_cur.thr_en[1] &  w_m.ul);
        {w_tx[2], w_nxt.thr_dl}  = charge(w_cur.thr_dl,  w_m.len, w_cur.thr_en[2] & ~w_m.ul);
        if (w_m.ul) begin
            w_nxt.cnt_ul = w_cur.cnt_ul + FLD_W'(1);
        end else begin
            w_nxt.cnt_dl = w_cur.cnt_dl + FLD_W'(1);
        end
        w_nxt.last_ts = FLD_W'(timer);
        w_wr_rec = pack_record(w_src, w_nxt);

        w_qpol = policy_of(|w_qx, w_cur.quo_host);
        w_tpol = policy_of(|w_tx, w_cur.thr_host);
        w_pol  = (w_qpol < w_tpol) ? w_qpol : w_tpol;
        w_rpt  = {2'b00, w_cur.thr_en, w_cur.quo_en, w_m.id};
        if (!w_m.cnt_en) begin
            w_pol = POLICY_PASS;
            w_rpt = {8'h00, w_m.id};
        end
        w_out = {w_m.cnt_en, w_rpt, w_m.ul, w_pol, w_m.pid, w_m.len};
    end

    // Stage C: registered write-back and annotated descriptor
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            r_c_valid <= 1'b0;
            r_c_wr    <= 1'b0;
            r_c_id    <= '0;
            r_c_rec   <= '0;
            r_c_out   <= '0;
        end else begin
            r_c_valid <= w_m_vld;
            r_c_wr    <= w_m_vld & w_m.cnt_en;
            if (w_m_vld) begin
                r_c_out <= w_out;
            end
            if (w_m_vld && w_m.cnt_en) begin
                r_c_id  <= w_m.id;
                r_c_rec <= w_wr_rec;
            end
        end
    end

    assign mem_wr_en   = r_c_wr;
    assign mem_wr_addr = r_c_id;
    assign mem_wr_data = r_c_rec;

    // Output register toward the egress FIFO
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_c_valid;
            if (r_c_valid) begin
                r_out_data <= r_c_out;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_charging_counter_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_charging_counter_pipe
//  Purpose  : Directed self-checking bench for charging_counter_pipe with a
//             behavioural counter RAM (old data on same-cycle read/write).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_charging_counter_pipe;
    import charging_pkg::*;

    localparam int ID_W   = 14;
    localparam int LEN_W  = 16;
    localparam int PID_W  = 96;
    localparam int VOL_W  = 48;
    localparam int TS_W   = 24;
    localparam int RD_LAT = 2;
    localparam int IN_W   = 2 + ID_W + PID_W + LEN_W;
    localparam int OUT_W  = 1 + RPT_W + 1 + 3 + PID_W + LEN_W;

    logic                asclk = 1'b0;
    logic                aresetn;
    logic [TS_W-1:0]     timer;
    logic [IN_W-1:0]     in_data;
    logic                in_valid;
    logic                in_ready;
    logic                mem_rd_en;
    logic [ID_W-1:0]     mem_rd_addr;
    logic [REC_W-1:0]    mem_rd_data;
    logic                mem_wr_en;
    logic [ID_W-1:0]     mem_wr_addr;
    logic [REC_W-1:0]    mem_wr_data;
    logic                out_afull;
    logic                out_valid;
    logic [OUT_W-1:0]    out_data;

    always #5 asclk = ~asclk;

    charging_counter_pipe #(
        .ID_W(ID_W), .LEN_W(LEN_W), .PID_W(PID_W),
        .VOL_W(VOL_W), .TS_W(TS_W), .RD_LAT(RD_LAT)
    ) dut (
        .asclk       (asclk),
        .aresetn     (aresetn),
        .timer       (timer),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .out_afull   (out_afull),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

    // Counter RAM model; ids used here stay below 64
    logic [REC_W-1:0] ram     [0:63];
    logic [REC_W-1:0] rd_pipe [0:RD_LAT-1];
    logic             bd_en;
    logic [5:0]       bd_addr;
    logic [REC_W-1:0] bd_data;

    always @(posedge asclk) begin
        if (bd_en) ram[bd_addr] <= bd_data;
        else if (mem_wr_en) ram[mem_wr_addr[5:0]] <= mem_wr_data;
        rd_pipe[0] <= mem_rd_en ? ram[mem_rd_addr[5:0]] : '0;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rd_data = rd_pipe[RD_LAT-1];

    // Cycle counter and event logging (sampled on the falling edge)
    int cyc = 0;
    always @(posedge asclk) cyc <= cyc + 1;

    int               pop_q[$];
    int               out_cyc_q[$];
    logic [OUT_W-1:0] out_q[$];
    logic [ID_W-1:0]  wr_id_q[$];
    logic [REC_W-1:0] wr_q[$];
    int               rd_cnt;

    always @(negedge asclk) begin
        if (in_valid && in_ready) pop_q.push_back(cyc);
        if (out_valid) begin
            out_q.push_back(out_data);
            out_cyc_q.push_back(cyc);
        end
        if (mem_wr_en) begin
            wr_id_q.push_back(mem_wr_addr);
            wr_q.push_back(mem_wr_data);
        end
        if (mem_rd_en) rd_cnt++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [REC_W-1:0] mk_rec(
        input logic [2:0] qe, input logic qh, input logic [47:0] qt, input logic [47:0] qu, input logic [47:0] qd,
        input logic [2:0] te, input logic th, input logic [47:0] tt, input logic [47:0] tu, input logic [47:0] td,
        input logic [47:0] cu, input logic [47:0] cd, input logic [47:0] ts);
        logic [REC_W-1:0] r;
        r = '0;
        r[7:4]     = 4'h5;
        r[159:156] = 4'h9;
        r[463:400] = 64'hDEAD_BEEF_0123_4567;
        r[2:0] = qe;      r[3] = qh;
        r[55:8] = qt;     r[103:56] = qu;   r[151:104] = qd;
        r[154:152] = te;  r[155] = th;
        r[207:160] = tt;  r[255:208] = tu;  r[303:256] = td;
        r[351:304] = cu;  r[399:352] = cd;  r[511:464] = ts;
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] mk_out(input logic cen, input logic [2:0] te, input logic [2:0] qe,
        input logic [ID_W-1:0] id, input logic ul, input logic [2:0] pol, input logic [PID_W-1:0] pid,
        input logic [LEN_W-1:0] len);
        return {cen, 2'b00, te, qe, id, ul, pol, pid, len};
    endfunction

    task automatic clr();
        pop_q.delete(); out_cyc_q.delete(); out_q.delete();
        wr_id_q.delete(); wr_q.delete(); rd_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge asclk);
        #1;
    endtask

    task automatic preload(input logic [5:0] id, input logic [REC_W-1:0] rec);
        bd_en = 1'b1; bd_addr = id; bd_data = rec;
        @(posedge asclk); #1;
        bd_en = 1'b0;
    endtask

    task automatic send(input logic ul, input logic cen, input logic [ID_W-1:0] id,
                        input logic [LEN_W-1:0] len, input logic [PID_W-1:0] pid);
        int tries;
        tries = 0;
        in_valid = 1'b1;
        in_data  = {ul, cen, id, pid, len};
        forever begin
            @(negedge asclk);
            if (in_ready) begin
                @(posedge asclk); #1;
                break;
            end
            tries++;
            if (tries > 50) begin
                chk("send_timeout", in_ready, 1);
                break;
            end
            @(posedge asclk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [OUT_W-1:0] o;
        aresetn = 1'b0; in_valid = 1'b0; in_data = '0; out_afull = 1'b0;
        timer = '0; bd_en = 1'b0; bd_addr = '0; bd_data = '0; rd_cnt = 0;
        idle(3);

        // Reset state
        @(negedge asclk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge asclk); #1;
        aresetn = 1'b1;
        idle(2);

        // Test 1: single ul packet against total quota
        clr(); timer = 24'h123456;
        preload(5, mk_rec(3'b001, 0, 1000, 0, 0, 3'b000, 0, 0, 0, 0, 10, 3, 0));
        send(1, 1, 5, 300, 96'h1);
        idle(RD_LAT + 6);
        chk("t1_nwr", wr_q.size(), 1);
        chk("t1_nout", out_q.size(), 1);
        if (wr_q.size() >= 1) begin
            chk("t1_wr_id", wr_id_q[0], 5);
            chk("t1_wr_rec", wr_q[0], mk_rec(3'b001, 0, 700, 0, 0, 3'b000, 0, 0, 0, 0, 11, 3, 48'h123456));
        end
        if (out_q.size() >= 1) begin
            chk("t1_out", out_q[0], mk_out(1, 3'b000, 3'b001, 5, 1, 3'd4, 96'h1, 300));
            chk("t1_latency", out_cyc_q[0] - pop_q[0], RD_LAT + 3);
        end

        // Test 2: four back-to-back same-id packets (forwarding)
        clr(); timer = 24'h000777;
        preload(7, mk_rec(3'b001, 0, 1000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) send(0, 1, 7, 100, 96'h20 + i);
        idle(RD_LAT + 6);
        chk("t2_nwr", wr_q.size(), 4);
        chk("t2_nout", out_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++)
            chk($sformatf("t2_wr%0d", i), wr_q[i],
                mk_rec(3'b001, 0, 48'(1000 - 100*(i+1)), 0, 0, 3'b000, 0, 0, 0, 0, 0, 48'(i+1), 48'h777));
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            chk($sformatf("t2_out%0d", i), out_q[i], mk_out(1, 3'b000, 3'b001, 7, 0, 3'd4, 96'h20 + i, 100));
            chk($sformatf("t2_gap%0d", i), out_cyc_q[i] - out_cyc_q[0], i);
        end

        // Test 3: ul quota with send-to-host, exhausted by second packet
        clr(); timer = 24'h00ABCD;
        preload(11, mk_rec(3'b010, 1, 5000, 250, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        send(1, 1, 11, 200, 96'h30);
        send(1, 1, 11, 200, 96'h31);
        idle(RD_LAT + 6);
        chk("t3_nwr", wr_q.size(), 2);
        if (wr_q.size() >= 2) begin
            chk("t3_wr0", wr_q[0], mk_rec(3'b010, 1, 5000, 50, 0, 3'b000, 0, 0, 0, 0, 1, 0, 48'hABCD));
            chk("t3_wr1", wr_q[1], mk_rec(3'b010, 1, 5000, 0, 0, 3'b000, 0, 0, 0, 0, 2, 0, 48'hABCD));
        end
        if (out_q.size() >= 2) begin
            chk("t3_out0", out_q[0], mk_out(1, 3'b000, 3'b010, 11, 1, 3'd4, 96'h30, 200));
            chk("t3_out1", out_q[1], mk_out(1, 3'b000, 3'b010, 11, 1, 3'd2, 96'h31, 200));
        end

        // Test 4: threshold drop, dual host exceed, exact-equal, non-applicable + count wrap
        clr(); timer = 24'h0BEEF0;
        preload(12, mk_rec(3'b001, 0, 1000, 0, 0, 3'b001, 0, 50, 0, 0, 0, 0, 0));
        preload(13, mk_rec(3'b100, 1, 0, 0, 10, 3'b100, 1, 0, 0, 10, 0, 0, 0));
        preload(14, mk_rec(3'b001, 1, 100, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        preload(15, mk_rec(3'b010, 1, 0, 50, 0, 3'b000, 0, 0, 0, 0, 0, 48'hFFFF_FFFF_FFFF, 0));
        send(0, 1, 12, 100, 96'h40);
        send(0, 1, 13, 100, 96'h41);
        send(1, 1, 14, 100, 96'h42);
        send(0, 1, 15, 100, 96'h43);
        idle(RD_LAT + 6);
        chk("t4_nwr", wr_q.size(), 4);
        if (wr_q.size() >= 4) begin
            chk("t4_wr_thr", wr_q[0], mk_rec(3'b001, 0, 900, 0, 0, 3'b001, 0, 0, 0, 0, 0, 1, 48'h0BEEF0));
            chk("t4_wr_both", wr_q[1], mk_rec(3'b100, 1, 0, 0, 0, 3'b100, 1, 0, 0, 0, 0, 1, 48'h0BEEF0));
            chk("t4_wr_equal", wr_q[2], mk_rec(3'b001, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 48'h0BEEF0));
            chk("t4_wr_wrap", wr_q[3], mk_rec(3'b010, 1, 0, 50, 0, 3'b000, 0, 0, 0, 0, 0, 0, 48'h0BEEF0));
        end
        if (out_q.size() >= 4) begin
            chk("t4_out_thr", out_q[0], mk_out(1, 3'b001, 3'b001, 12, 0, 3'd1, 96'h40, 100));
            chk("t4_out_both", out_q[1], mk_out(1, 3'b100, 3'b100, 13, 0, 3'd2, 96'h41, 100));
            chk("t4_out_equal", out_q[2], mk_out(1, 3'b000, 3'b001, 14, 1, 3'd4, 96'h42, 100));
            chk("t4_out_na", out_q[3], mk_out(1, 3'b000, 3'b010, 15, 0, 3'd4, 96'h43, 100));
        end

        // Test 5: cnt_en=0 bypass
        clr();
        send(1, 0, 9, 64, 96'h50);
        idle(RD_LAT + 6);
        chk("t5_rd_cnt", rd_cnt, 0);
        chk("t5_nwr", wr_q.size(), 0);
        chk("t5_nout", out_q.size(), 1);
        if (out_q.size() >= 1) begin
            chk("t5_out", out_q[0], mk_out(0, 3'b000, 3'b000, 9, 1, 3'd4, 96'h50, 64));
            chk("t5_latency", out_cyc_q[0] - pop_q[0], RD_LAT + 3);
        end

        // Test 6a: out_afull raised mid-burst
        clr(); timer = 24'h000042;
        preload(20, mk_rec(3'b001, 0, 10000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        send(1, 1, 20, 10, 96'h60);
        send(1, 1, 20, 10, 96'h61);
        in_valid = 1'b1; in_data = {1'b1, 1'b1, 14'd20, 96'h62, 16'd10}; out_afull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge asclk);
            chk($sformatf("t6_ready_low%0d", i), in_ready, 0);
            @(posedge asclk); #1;
        end
        out_afull = 1'b0;
        for (int i = 2; i < 6; i++) send(1, 1, 20, 10, 96'h60 + i);
        idle(RD_LAT + 6);
        chk("t6_nwr", wr_q.size(), 6);
        chk("t6_nout", out_q.size(), 6);
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            o = out_q[i];
            chk($sformatf("t6_pid%0d", i), o[LEN_W +: PID_W], 96'h60 + i);
        end
        if (wr_q.size() >= 6)
            chk("t6_wr_last", wr_q[5], mk_rec(3'b001, 0, 9940, 0, 0, 3'b000, 0, 0, 0, 0, 6, 0, 48'h42));

        // Test 6b: reset with three packets in flight
        clr(); timer = 24'h000099;
        preload(21, mk_rec(3'b001, 0, 500, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) send(1, 1, 21, 10, 96'h70 + i);
        aresetn = 1'b0;
        idle(2);
        aresetn = 1'b1;
        idle(RD_LAT + 8);
        chk("t6r_nwr", wr_q.size(), 0);
        chk("t6r_nout", out_q.size(), 0);
        send(1, 1, 21, 10, 96'h7F);
        idle(RD_LAT + 6);
        chk("t6r_post_nwr", wr_q.size(), 1);
        if (wr_q.size() >= 1)
            chk("t6r_post_wr", wr_q[0], mk_rec(3'b001, 0, 490, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 48'h99));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
